// File: rtl/cuckoo_table_loader.sv
// -----------------------------------------------------------------------------
// cuckoo_table_loader
//
// Inserts 14-byte patterns into a two-way cuckoo index. Each accepted command
// is hashed with two independently seeded hashes, one byte per cycle. The
// pattern is then placed in the first free table, T1 before T2. No eviction is
// performed. A successful placement writes the pattern (with its suffix code)
// to the next free pattern-RAM slot. It also writes that slot number into the
// index RAM at the chosen table/hash address.
//
// Optional feature (macro CUCKOO_LOADER_CLEAR_EN): a high clear input sampled
// in IDLE sweeps zeros through all 2048 index-RAM entries. It also resets the
// valid bitmaps and the slot counter. Without the macro, clear is ignored.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   cmd_valid / cmd_ready          insert-command handshake
//   cmd_pattern [111:0]            pattern, byte k = cmd_pattern[8k+7:8k]
//   cmd_suffix  [1:0]              suffix code stored alongside the pattern
//   clear                          table-clear request
//   idx_we / idx_addr / idx_din    index RAM write port (addr[10] = table)
//   pat_we / pat_addr / pat_din    pattern RAM write port ({suffix, pattern})
//   done_valid                     one-cycle completion pulse
//   done_status [1:0]              00 T1, 01 T2, 10 collision, 11 RAM full
//   done_slot   [8:0]              slot written (0 for status 10/11)
//   busy                           FSM not idle
// -----------------------------------------------------------------------------
module cuckoo_table_loader #(
   parameter logic [9:0] SEED_T1 = 10'h000,
   parameter logic [9:0] SEED_T2 = 10'h2A5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [111:0] cmd_pattern,
   input  logic [1:0]   cmd_suffix,
   input  logic         clear,
   output logic         idx_we,
   output logic [10:0]  idx_addr,
   output logic [8:0]   idx_din,
   output logic         pat_we,
   output logic [8:0]   pat_addr,
   output logic [113:0] pat_din,
   output logic         done_valid,
   output logic [1:0]   done_status,
   output logic [8:0]   done_slot,
   output logic         busy
);

`ifdef CUCKOO_LOADER_CLEAR_EN
   typedef enum logic [2:0] {IDLE, HASH, PLACE, WRITE, CLEAR} state_t;
`else
   typedef enum logic [2:0] {IDLE, HASH, PLACE, WRITE} state_t;
`endif

   state_t        state, state_next;
   logic [111:0]  pat_q;
   logic [1:0]    suffix_q;
   logic [9:0]    h1, h2;
   logic [3:0]    byte_idx;
   logic [1:0]    status_q;
   logic [9:0]    slot_cnt;      // 1..512; 512 means the pattern RAM is full
   logic [1023:0] valid_t1, valid_t2;
   logic [7:0]    cur_byte;
   logic          placed;

`ifdef CUCKOO_LOADER_CLEAR_EN
   logic [10:0]   clr_cnt;
`else
   logic          unused_clear;
   assign unused_clear = clear;
`endif

   // One hash step: (h<<3) + (h>>3) + byte, folded back with h, kept to 10 bits.
   function automatic logic [9:0] hash_step(input logic [9:0] h, input logic [7:0] b);
      logic [9:0] sum;
      sum = {h[6:0], 3'b000} + {3'b000, h[9:3]} + {2'b00, b};
      return sum ^ h;
   endfunction

   assign cur_byte = pat_q[{byte_idx, 3'b000} +: 8];
   assign placed   = ~status_q[1];

   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create order-dependent races.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      state_next  = state;
      cmd_ready   = 1'b0;
      busy        = (state != IDLE);
      idx_we      = 1'b0;
      idx_addr    = '0;
      idx_din     = '0;
      pat_we      = 1'b0;
      pat_addr    = '0;
      pat_din     = '0;
      done_valid  = 1'b0;
      done_status = '0;
      done_slot   = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
`ifdef CUCKOO_LOADER_CLEAR_EN
            // A clear request wins over a simultaneous command.
            if (clear) begin
               cmd_ready  = 1'b0;
               state_next = CLEAR;
            end else
`endif
            if (cmd_valid) state_next = HASH;
         end
         HASH: begin
            if (byte_idx == 4'd13) state_next = PLACE;
         end
         PLACE: state_next = WRITE;
         WRITE: begin
            done_valid  = 1'b1;
            done_status = status_q;
            if (placed) begin
               done_slot = slot_cnt[8:0];
               pat_we    = 1'b1;
               pat_addr  = slot_cnt[8:0];
               pat_din   = {suffix_q, pat_q};
               idx_we    = 1'b1;
               idx_addr  = {status_q[0], status_q[0] ? h2 : h1};
               idx_din   = slot_cnt[8:0];
            end
            state_next = IDLE;
         end
`ifdef CUCKOO_LOADER_CLEAR_EN
         CLEAR: begin
            idx_we   = 1'b1;
            idx_addr = clr_cnt;
            if (clr_cnt == 11'd2047) state_next = IDLE;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q    <= '0;
         suffix_q <= '0;
         h1       <= '0;
         h2       <= '0;
         byte_idx <= '0;
         status_q <= '0;
         slot_cnt <= 10'd1;
         // NOTE: the valid bitmaps are architectural state that decides
         // placement, so unlike a RAM array they must be cleared by reset.
         valid_t1 <= '0;
         valid_t2 <= '0;
`ifdef CUCKOO_LOADER_CLEAR_EN
         clr_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (state_next == HASH) begin
                  pat_q    <= cmd_pattern;
                  suffix_q <= cmd_suffix;
                  h1       <= SEED_T1;
                  h2       <= SEED_T2;
                  byte_idx <= '0;
               end
`ifdef CUCKOO_LOADER_CLEAR_EN
               if (state_next == CLEAR) begin
                  valid_t1 <= '0;
                  valid_t2 <= '0;
                  slot_cnt <= 10'd1;
                  clr_cnt  <= '0;
               end
`endif
            end
            HASH: begin
               h1       <= hash_step(h1, cur_byte);
               h2       <= hash_step(h2, cur_byte);
               byte_idx <= byte_idx + 4'd1;
            end
            PLACE: begin
               if (slot_cnt == 10'd512) status_q <= 2'b11;
               else if (!valid_t1[h1])  status_q <= 2'b00;
               else if (!valid_t2[h2])  status_q <= 2'b01;
               else                     status_q <= 2'b10;
            end
            WRITE: begin
               if (placed) begin
                  if (status_q[0]) valid_t2[h2] <= 1'b1;
                  else             valid_t1[h1] <= 1'b1;
                  slot_cnt <= slot_cnt + 10'd1;
               end
            end
`ifdef CUCKOO_LOADER_CLEAR_EN
            CLEAR: clr_cnt <= clr_cnt + 11'd1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cuckoo_table_loader.sv
// -----------------------------------------------------------------------------
// tb_cuckoo_table_loader
//
// Self-checking bench for cuckoo_table_loader. A reference model tracks the
// two valid tables and the next free slot, and computes both hashes with
// plain integer arithmetic. Each done pulse is compared against what that
// model predicts.
// -----------------------------------------------------------------------------
module tb_cuckoo_table_loader;

   localparam int SEED1 = 'h000;
   localparam int SEED2 = 'h2A5;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [111:0] cmd_pattern;
   logic [1:0]   cmd_suffix;
   logic         clear;
   logic         idx_we;
   logic [10:0]  idx_addr;
   logic [8:0]   idx_din;
   logic         pat_we;
   logic [8:0]   pat_addr;
   logic [113:0] pat_din;
   logic         done_valid;
   logic [1:0]   done_status;
   logic [8:0]   done_slot;
   logic         busy;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   bit mdl_t1[1024];
   bit mdl_t2[1024];
   int mdl_slot;

   cuckoo_table_loader dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_pattern(cmd_pattern), .cmd_suffix(cmd_suffix), .clear(clear),
      .idx_we(idx_we), .idx_addr(idx_addr), .idx_din(idx_din),
      .pat_we(pat_we), .pat_addr(pat_addr), .pat_din(pat_din),
      .done_valid(done_valid), .done_status(done_status), .done_slot(done_slot),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_hash(input int seed, input logic [111:0] p);
      int h;
      h = seed;
      for (int k = 0; k < 14; k++) begin
         int b;
         b = int'(p[8*k +: 8]);
         h = (((h * 8) % 1024 + h / 8 + b) % 1024) ^ h;
      end
      return h;
   endfunction

   function automatic logic [111:0] rand_pat();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[111:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 1024; i++) begin
         mdl_t1[i] = 1'b0;
         mdl_t2[i] = 1'b0;
      end
      mdl_slot = 1;
   endtask

   // Called at a sample point where done_valid is high.
   task automatic expect_done(input logic [111:0] p, input logic [1:0] s,
                              output logic [1:0] st_obs, output logic [8:0] sl_obs);
      int h1, h2, st;
      bit placed;
      h1 = ref_hash(SEED1, p);
      h2 = ref_hash(SEED2, p);
      if (mdl_slot == 512)  st = 3;
      else if (!mdl_t1[h1]) st = 0;
      else if (!mdl_t2[h2]) st = 1;
      else                  st = 2;
      placed = (st < 2);
      check("done_status", done_status, st);
      check("done_slot", done_slot, placed ? mdl_slot : 0);
      check("pat_we", pat_we, placed);
      check("idx_we", idx_we, placed);
      check("ready_in_write", cmd_ready, 0);
      check("busy_in_write", busy, 1);
      if (placed) begin
         check("pat_addr", pat_addr, mdl_slot);
         check("pat_din", pat_din, {s, p});
         check("idx_addr", idx_addr, (st == 1) ? 1024 + h2 : h1);
         check("idx_din", idx_din, mdl_slot);
         if (st == 1) mdl_t2[h2] = 1'b1;
         else         mdl_t1[h1] = 1'b1;
         mdl_slot++;
      end
      st_obs = done_status;
      sl_obs = done_slot;
   endtask

   // One complete insert with cmd_valid dropped right after the handshake.
   task automatic insert(input logic [111:0] p, input logic [1:0] s,
                         output logic [1:0] st, output logic [8:0] sl);
      int cyc;
      int early;
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_pattern = p;
      cmd_suffix  = s;
      check("ready_before_cmd", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid   = 1'b0;
      cmd_pattern = rand_pat();   // must not disturb the latched copy
      cmd_suffix  = ~s;
      cyc   = -1;
      early = 0;
      st    = 2'b00;
      sl    = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_valid === 1'b1) begin
            cyc = c;
            break;
         end
         if (idx_we !== 1'b0 || pat_we !== 1'b0) early++;
      end
      check("done_latency", cyc, 15);
      check("no_early_writes", early, 0);
      if (cyc >= 0) expect_done(p, s, st, sl);
   endtask

   initial begin
      logic [111:0] pa, pc;
      logic [1:0]   st;
      logic [8:0]   sl;
      int           low, dones, bad, n, last_slot;

      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_pattern = '0;
      cmd_suffix  = '0;
      clear       = 1'b0;
      model_reset();

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done_valid", done_valid, 0);
      check("rst_idx_we", idx_we, 0);
      check("rst_pat_we", pat_we, 0);
      check("rst_done_status", done_status, 0);
      check("rst_done_slot", done_slot, 0);
      check("rst_pat_din", pat_din, 0);
      rst = 1'b0;

      // First insert, then the same pattern twice more.
      pa = {14{8'h41}};
      insert(pa, 2'b01, st, sl);
      check("first_status", st, 2'b00);
      check("first_slot", sl, 1);
      insert(pa, 2'b01, st, sl);
      check("second_status", st, 2'b01);
      check("second_slot", sl, 2);
      insert(pa, 2'b01, st, sl);
      check("third_status", st, 2'b10);
      check("third_slot", sl, 0);

      // cmd_valid held high across three back-to-back commands.
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_pattern = rand_pat();
      cmd_suffix  = 2'($urandom_range(0, 3));
      for (int i = 0; i < 3; i++) begin
         logic [111:0] p_cur;
         logic [1:0]   s_cur;
         check("held_ready", cmd_ready, 1);
         p_cur = cmd_pattern;
         s_cur = cmd_suffix;
         @(posedge clk);
         low   = 0;
         dones = 0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_valid === 1'b1) begin
               dones++;
               expect_done(p_cur, s_cur, st, sl);
            end
            if (cmd_ready === 1'b1) break;
            low++;
            if (c == 0) begin
               cmd_pattern = rand_pat();
               cmd_suffix  = 2'($urandom_range(0, 3));
            end
         end
         check("held_ready_low_cycles", low, 16);
         check("held_done_count", dones, 1);
      end
      cmd_valid = 1'b0;

      // Reset in the middle of HASH.
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_pattern = rand_pat();
      cmd_suffix  = 2'b11;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_cmd_ready", cmd_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_idx_we", idx_we, 0);
      check("abort_pat_we", pat_we, 0);
      check("abort_done", done_valid, 0);
      rst = 1'b0;
      model_reset();
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (idx_we !== 1'b0 || pat_we !== 1'b0 || done_valid !== 1'b0) bad++;
      end
      check("abort_quiet", bad, 0);
      insert(rand_pat(), 2'b00, st, sl);
      check("abort_next_slot", sl, 1);

      // Fill the pattern RAM, then one more insert.
      n         = 0;
      last_slot = 0;
      while (mdl_slot < 512 && n < 3000) begin
         insert(rand_pat(), 2'($urandom_range(0, 3)), st, sl);
         if (st < 2) last_slot = int'(sl);
         n++;
      end
      check("fill_last_slot", last_slot, 511);
      insert(rand_pat(), 2'b10, st, sl);
      check("full_status", st, 2'b11);
      check("full_slot", sl, 0);

`ifdef CUCKOO_LOADER_CLEAR_EN
      // Clear and a command together: clear first, then the command.
      pc = rand_pat();
      @(negedge clk);
      clear       = 1'b1;
      cmd_valid   = 1'b1;
      cmd_pattern = pc;
      cmd_suffix  = 2'b10;
      check("clear_priority_ready", cmd_ready, 0);
      @(posedge clk);
      #1 clear = 1'b0;
      bad = 0;
      for (int i = 0; i < 2048; i++) begin
         @(negedge clk);
         if (!(idx_we === 1'b1 && idx_addr === 11'(i) && idx_din === 9'd0 &&
               pat_we === 1'b0 && done_valid === 1'b0 && cmd_ready === 1'b0)) bad++;
      end
      check("clear_sweep", bad, 0);
      model_reset();
      insert(pc, 2'b10, st, sl);
      check("after_clear_status", st, 2'b00);
      check("after_clear_slot", sl, 1);
`else
      // clear has no effect: the command is taken and the RAM is still full.
      pc    = rand_pat();
      clear = 1'b1;
      insert(pc, 2'b10, st, sl);
      clear = 1'b0;
      check("clear_ignored_status", st, 2'b11);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
